fifo_block_reader: RTL



---
 rtl/fifo_block_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_block_reader.sv
// Drains FIFO words (one-cycle read latency) and packs WORDS_PER_BLOCK of them into a block.
// The block is handed to the AES core over a valid/ready handshake. The first word read lands in the top slice.
module fifo_block_reader #(
  parameter  int DATA_WIDTH      = 32,
  parameter  int WORDS_PER_BLOCK = 4,
  localparam int BLOCK_W         = DATA_WIDTH * WORDS_PER_BLOCK,
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fifo_empty,
  output logic                  read_fifo,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  clear,
  output logic [BLOCK_W-1:0]    block_out,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic [CNT_W-1:0]      word_count
);

  typedef enum logic {FETCH, HOLD} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic               rd_pending_q, rd_pending_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               block_valid_q, block_valid_d;

  // NOTE: every state element takes its reset value, the wide block register included.
  // After a reset, block_out must read as zero.
  // NOTE: non-blocking assignments keep all registers sampling the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= FETCH;
      req_cnt_q     <= '0;
      word_count_q  <= '0;
      rd_pending_q  <= 1'b0;
      block_q       <= '0;
      block_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_cnt_q     <= req_cnt_d;
      word_count_q  <= word_count_d;
      rd_pending_q  <= rd_pending_d;
      block_q       <= block_d;
      block_valid_q <= block_valid_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    word_count_d  = word_count_q;
    rd_pending_d  = read_fifo;
    block_d       = block_q;
    block_valid_d = block_valid_q;
    if (clear) begin
      // An in-flight read's data is dropped along with the partial block.
      state_d       = FETCH;
      req_cnt_d     = '0;
      word_count_d  = '0;
      rd_pending_d  = 1'b0;
      block_valid_d = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (read_fifo) req_cnt_d = req_cnt_q + CNT_ONE;
          if (rd_pending_q) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
              if (word_count_q == CNT_W'(i))
                block_d[BLOCK_W-DATA_WIDTH*(i+1) +: DATA_WIDTH] = fifo_data_out;
            end
            word_count_d = word_count_q + CNT_ONE;
            if (word_count_q == CNT_LAST) begin
              state_d       = HOLD;
              block_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (block_valid_q && block_ready) begin
            state_d       = FETCH;
            req_cnt_d     = '0;
            word_count_d  = '0;
            block_valid_d = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Gated by resetn so the request drops the instant reset asserts.
  always_comb begin
    read_fifo = 1'b0;
    if (resetn && (state_q == FETCH) && !fifo_empty && (req_cnt_q < CNT_FULL) && !clear)
      read_fifo = 1'b1;
  end

  assign block_out   = block_q;
  assign block_valid = block_valid_q;
  assign word_count  = word_count_q;

endmodule
